// File: rtl/regfile_seq_if.sv
// rtl/regfile_seq_if.sv - decode/ALU/register-file side bundle of the register file sequencer
// slave = sequencer view, master = environment (decode, ALU, register file) view.
interface regfile_seq_if #(
  parameter int DW = 6,
  parameter int AW = 3
);
  logic          op_valid;
  logic          op_ready;
  logic [AW-1:0] op_rs1;
  logic [AW-1:0] op_rs2;
  logic [AW-1:0] op_rd;
  logic          op_wb;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          opnd_valid;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          done;
  logic          err;
  logic [AW-1:0] reg_addr;
  logic          reg_we;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  modport slave (
    input  op_valid, op_rs1, op_rs2, op_rd, op_wb, res_valid, res_data, reg_rdata,
    output op_ready, opa, opb, opnd_valid, done, err, reg_addr, reg_we, reg_wdata
  );

  modport master (
    output op_valid, op_rs1, op_rs2, op_rd, op_wb, res_valid, res_data, reg_rdata,
    input  op_ready, opa, opb, opnd_valid, done, err, reg_addr, reg_we, reg_wdata
  );
endinterface

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - serialises rs1 read, rs2 read, ALU wait and rd write onto the single register file port
// Optional REGSEQ_SAME_SRC_EN: when rs1==rs2 the second read is skipped and both operands come from RD_A.
module regfile_seq #(
  parameter int DW      = 6,
  parameter int AW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  regfile_seq_if.slave bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [AW-1:0] r_rd;
  logic          r_wb;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_wdata;
  logic          r_opnd_valid;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          w_same;
  logic [AW-1:0] w_addr;

`ifdef REGSEQ_SAME_SRC_EN
  assign w_same = (r_rs1 == r_rs2);
`else
  assign w_same = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_wb         <= 1'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_wdata      <= '0;
      r_opnd_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            r_rs1   <= bus.op_rs1;
            r_rs2   <= bus.op_rs2;
            r_rd    <= bus.op_rd;
            r_wb    <= bus.op_wb;
            r_state <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_opa <= bus.reg_rdata;
          if (w_same) begin
            r_opb        <= bus.reg_rdata;
            r_opnd_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_EXEC;
          end else begin
            r_state <= S_RD_B;
          end
        end
        S_RD_B: begin
          r_opb        <= bus.reg_rdata;
          r_opnd_valid <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.res_valid) begin
            r_wdata      <= bus.res_data;
            r_opnd_valid <= 1'b0;
            // x0 is hard zero, so a write-back to it completes without a WB cycle
            if (r_wb && (r_rd != '0)) begin
              r_state <= S_WB;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
              r_err        <= 1'b1;
              r_opnd_valid <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        S_WB: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr = '0;
    case (r_state)
      S_RD_A:       w_addr = r_rs1;
      S_RD_B:       w_addr = r_rs2;
      S_EXEC, S_WB: w_addr = r_rd;
      default:      w_addr = '0;
    endcase
  end

  // Gated by reset so no register file write can land in a reset cycle
  assign bus.reg_we     = reset && (r_state == S_WB);
  assign bus.op_ready   = reset && (r_state == S_IDLE);
  assign bus.reg_addr   = w_addr;
  assign bus.reg_wdata  = r_wdata;
  assign bus.opa        = r_opa;
  assign bus.opb        = r_opb;
  assign bus.opnd_valid = r_opnd_valid;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - scoreboard bench for regfile_seq with a behavioural register file and reference model
// Define REGSEQ_SAME_SRC_EN for both RTL and bench to check the shortened same-source path.
module tb_regfile_seq;
  localparam int TO = 15;

  typedef struct {
    int         cyc;
    logic       is_err;
    logic [5:0] opa;
    logic [5:0] opb;
    logic       wr;
    logic [2:0] rd;
    logic [5:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] mem [8];
  logic [5:0] ref_regs [8];
  logic       pl_we = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [5:0] pl_data = '0;
  exp_t       sbq [$];

  regfile_seq_if #(.DW(6), .AW(3)) bus ();

  regfile_seq #(.DW(6), .AW(3), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: combinational read, x0 hard zero, write at the negedge
  always @(negedge clk) begin
    if (bus.reg_we && bus.reg_addr != 3'd0) mem[bus.reg_addr] <= bus.reg_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end
  assign bus.reg_rdata = (bus.reg_addr == 3'd0) ? 6'd0 : mem[bus.reg_addr];

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops one expectation per done/err pulse
  int         wr_n = 0;
  logic [2:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wr_n = 0;
      end else begin
        if (bus.reg_we) begin
          wr_n++;
          wr_addr = bus.reg_addr;
          wr_data = bus.reg_wdata;
        end
        if (bus.done || bus.err) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done_err", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("err_flag", int'(bus.err), int'(e.is_err));
            chk("done_flag", int'(bus.done), int'(!e.is_err));
            chk("finish_cycle", cyc, e.cyc);
            chk("opa", int'(bus.opa), int'(e.opa));
            chk("opb", int'(bus.opb), int'(e.opb));
            chk("write_count", wr_n, int'(e.wr));
            if (e.wr) begin
              chk("write_addr", int'(wr_addr), int'(e.rd));
              chk("write_data", int'(wr_data), int'(e.data));
            end
          end
          wr_n = 0;
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic wb, input logic [5:0] res, input int w, input bit tmo);
    exp_t e;
    int   lat;
    int   guard;
    bus.op_rs1   = rs1;
    bus.op_rs2   = rs2;
    bus.op_rd    = rd;
    bus.op_wb    = wb;
    bus.op_valid = 1'b1;
    guard = 0;
    while (!bus.op_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.op_ready) begin
      chk("accept_wait", 0, 1);
      bus.op_valid = 1'b0;
      return;
    end
    e.opa  = ref_regs[rs1];
    e.opb  = ref_regs[rs2];
    e.rd   = rd;
    e.data = res;
    e.wr   = 1'b0;
    if (tmo) begin
      e.is_err = 1'b1;
      lat = 2 + TO;
    end else begin
      e.is_err = 1'b0;
      lat = 3 + w;
      if (wb && rd != 3'd0) begin
        e.wr = 1'b1;
        ref_regs[rd] = res;
        lat++;
      end
    end
`ifdef REGSEQ_SAME_SRC_EN
    if (rs1 == rs2) lat--;
`endif
    // accept edge is the next posedge (cyc+1); c_k is seen at cyc == edge + k - 1
    e.cyc = cyc + 1 + lat;
    sbq.push_back(e);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_rs1   = 3'($urandom);
    bus.op_rs2   = 3'($urandom);
    bus.op_rd    = 3'($urandom);
    bus.op_wb    = 1'($urandom);
    guard = 0;
    while (!bus.opnd_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.opnd_valid) begin
      chk("exec_wait", 0, 1);
      return;
    end
    if (!tmo) begin
      repeat (w) @(negedge clk);
      bus.res_valid = 1'b1;
      bus.res_data  = res;
      @(negedge clk);
      bus.res_valid = 1'b0;
      bus.res_data  = 6'($urandom);
    end else begin
      guard = 0;
      while (bus.opnd_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
    end
  endtask

  initial begin
    int guard;
    bus.op_valid  = 1'b0;
    bus.op_rs1    = '0;
    bus.op_rs2    = '0;
    bus.op_rd     = '0;
    bus.op_wb     = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;

    // Preload under reset
    for (int i = 0; i < 8; i++) begin
      ref_regs[i] = (i == 0) ? 6'd0 : (i == 1) ? 6'd5 : (i == 2) ? 6'd9 :
                    (i == 6) ? 6'd42 : 6'($urandom);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = 3'(i);
      pl_data = ref_regs[i];
    end
    @(negedge clk);
    pl_we = 1'b0;
    chk("rst_op_ready", int'(bus.op_ready), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_opnd_valid", int'(bus.opnd_valid), 0);
    chk("rst_opa", int'(bus.opa), 0);
    chk("rst_opb", int'(bus.opb), 0);
    chk("rst_reg_we", int'(bus.reg_we), 0);
    chk("rst_reg_addr", int'(bus.reg_addr), 0);
    chk("rst_reg_wdata", int'(bus.reg_wdata), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_op_ready", int'(bus.op_ready), 1);

    run_op(3'd1, 3'd2, 3'd4, 1'b1, 6'd14, 0, 1'b0);
    run_op(3'd3, 3'd4, 3'd0, 1'b1, 6'd7, 0, 1'b0);
    run_op(3'd1, 3'd2, 3'd5, 1'b1, 6'd0, 0, 1'b1);
    chk("op_ready_after_timeout", int'(bus.op_ready), 1);
    run_op(3'd1, 3'd2, 3'd5, 1'b1, 6'd33, 1, 1'b0);
    run_op(3'd5, 3'd0, 3'd7, 1'b1, 6'd20, 0, 1'b0);
    run_op(3'd6, 3'd6, 3'd2, 1'b1, 6'd11, 0, 1'b0);

    // Reset asserted in the WB cycle of an op writing x3
    bus.op_rs1 = 3'd1; bus.op_rs2 = 3'd2; bus.op_rd = 3'd3; bus.op_wb = 1'b1;
    bus.op_valid = 1'b1;
    guard = 0;
    while (!bus.op_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    guard = 0;
    while (!bus.opnd_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.res_valid = 1'b1;
    bus.res_data  = ~ref_regs[3];
    @(posedge clk);
    #1 reset = 1'b0;
    bus.res_valid = 1'b0;
    @(negedge clk);
    chk("reset_wb_reg_we", int'(bus.reg_we), 0);
    chk("reset_wb_op_ready", int'(bus.op_ready), 0);
    @(negedge clk);
    chk("reset_mid_opa", int'(bus.opa), 0);
    chk("reset_mid_opb", int'(bus.opb), 0);
    chk("reset_mid_wdata", int'(bus.reg_wdata), 0);
    chk("reset_mid_addr", int'(bus.reg_addr), 0);
    chk("reset_mid_opnd_valid", int'(bus.opnd_valid), 0);
    chk("reset_mid_done_err", int'(bus.done | bus.err), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_x3_kept", int'(mem[3]), int'(ref_regs[3]));
    chk("reset_op_ready", int'(bus.op_ready), 1);

    for (int n = 0; n < 60; n++) begin
      run_op(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 6'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("final_x%0d", i), int'(mem[i]), int'(ref_regs[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
